cpu_run_ctrl: RTL and testbench

- Sits directly downstream of the slow-clock divider and turns its slow square wave (`tick_in`) into single-cycle clock-enable pulses for the processor core.
- The core itself runs on the fast board clock.
- Provides board-level run control: free-run switch, debounced single-step button, and halt-on-HALT-instruction.
- Also keeps an executed-cycle counter for display/debug.

---
 rtl/cpu_run_ctrl_if.sv | 36 +++
 rtl/cpu_run_ctrl.sv | 124 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between the slow-clock divider, board inputs and the core.
// The controller takes the slave side; the board/bench side takes master.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             tick_in;
    logic             run_sw;
    logic             step_btn;
    logic             halt_req;
    logic             cpu_en;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    modport slave (
        input  tick_in,
        input  run_sw,
        input  step_btn,
        input  halt_req,
        output cpu_en,
        output running,
        output halted,
        output cycle_count
    );

    modport master (
        output tick_in,
        output run_sw,
        output step_btn,
        output halt_req,
        input  cpu_en,
        input  running,
        input  halted,
        input  cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Converts the divider's slow square wave into single-clk core enables, with
// free-run / single-step / halt control and a saturating executed-cycle counter.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DB_W            = 20,
    parameter int unsigned CNT_W           = 32
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, HALTED} state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the run switch, bit 1 the step button.
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      db_q;
    logic [DB_W-1:0] dbcnt_q [2];
    logic            step_prev_q;
    logic            tick_dly_q;

    state_t          state_q;
    logic            cpu_en_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic            tick_rise;
    logic            step_pulse;
    logic            run_lvl;

    assign tick_rise  = bus.tick_in & ~tick_dly_q;
    assign run_lvl    = db_q[0];
    assign step_pulse = db_q[1] & ~step_prev_q;

    // tick_dly_q resets high so a tick already high at release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            db_q        <= 2'b00;
            step_prev_q <= 1'b0;
            tick_dly_q  <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                dbcnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= {bus.step_btn, bus.run_sw};
            sync2_q     <= sync1_q;
            step_prev_q <= db_q[1];
            tick_dly_q  <= bus.tick_in;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    dbcnt_q[i] <= '0;
                end else if (dbcnt_q[i] == DB_LAST) begin
                    db_q[i]    <= ~db_q[i];
                    dbcnt_q[i] <= '0;
                end else begin
                    dbcnt_q[i] <= dbcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cpu_en_q <= 1'b0;
        end else if (bus.halt_req && state_q != HALTED) begin
            state_q  <= HALTED;
            cpu_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cpu_en_q <= 1'b0;
                    if (run_lvl) begin
                        state_q <= RUN;
                    end else if (step_pulse) begin
                        state_q <= STEP_WAIT;
                    end
                end
                RUN: begin
                    if (!run_lvl) begin
                        state_q  <= IDLE;
                        cpu_en_q <= 1'b0;
                    end else begin
                        cpu_en_q <= tick_rise;
                    end
                end
                STEP_WAIT: begin
                    cpu_en_q <= tick_rise;
                    if (tick_rise) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cpu_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturates at all-ones; only reset clears it, halting does not.
    always_comb begin
        cnt_d = cnt_q;
        if (cpu_en_q && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cpu_en      = cpu_en_q;
    assign bus.running     = (state_q == RUN);
    assign bus.halted      = (state_q == HALTED);
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: expected enable pulses are queued by the
// stimulus and consumed by a negedge monitor whenever cpu_en is seen high.
module tb_cpu_run_ctrl;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_q[$];
    int   exp_count = 0;
    int   mon_e;

    cpu_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DB_W           (20),
        .CNT_W          (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Free-running slow clock: high for cycles 10..19 of every 20, so the
    // registered enable for a rise is seen at cycle phase 11.
    initial begin
        bus.tick_in = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1 bus.tick_in = ((cyc / 10) % 2) == 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required run to complete");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!rst && bus.cpu_en === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.cycle_count !== CNT_W'(mon_e) || (cyc % 20) != 11) begin
                    miscompares++;
                    $display("FAIL pulse: count=%0d phase=%0d, required count=%0d phase=11",
                             bus.cycle_count, cyc % 20, mon_e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int p);
        do begin
            @(posedge clk);
            #1;
        end while ((cyc % 20) != p);
    endtask

    task automatic push_pulse();
        exp_q.push_back(exp_count);
        if (exp_count < SAT) exp_count++;
    endtask

    initial begin
        bus.run_sw   = 1'b0;
        bus.step_btn = 1'b0;
        bus.halt_req = 1'b0;
        rst          = 1'b1;

        // Reset
        step_cyc(3);
        check("rst_cpu_en", bus.cpu_en, 0);
        check("rst_running", bus.running, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_count", bus.cycle_count, 0);
        rst = 1'b0;
        step_cyc(10);
        check("post_rst_pulses", exp_q.size(), 0);

        // Free run: RUN 7 clks after the switch, 5 pulses over 5 rises
        wait_phase(0);
        for (int i = 0; i < 5; i++) push_pulse();
        bus.run_sw = 1'b1;
        step_cyc(6);
        check("run_latency_6", bus.running, 0);
        step_cyc(1);
        check("run_latency_7", bus.running, 1);
        repeat (5) wait_phase(15);
        check("freerun_outstanding", exp_q.size(), 0);
        check("freerun_count", bus.cycle_count, 5);

        // Run release
        wait_phase(0);
        bus.run_sw = 1'b0;
        step_cyc(6);
        check("release_latency_6", bus.running, 1);
        step_cyc(1);
        check("release_latency_7", bus.running, 0);
        wait_phase(15);
        check("release_count", bus.cycle_count, 5);

        // Step held 20 clks -> one pulse
        wait_phase(0);
        push_pulse();
        bus.step_btn = 1'b1;
        step_cyc(20);
        bus.step_btn = 1'b0;
        step_cyc(12);
        check("step_outstanding", exp_q.size(), 0);
        check("step_count", bus.cycle_count, 6);
        check("step_running", bus.running, 0);

        // 3-clk glitch is rejected
        wait_phase(0);
        bus.step_btn = 1'b1;
        step_cyc(3);
        bus.step_btn = 1'b0;
        wait_phase(15);
        wait_phase(15);
        check("glitch_count", bus.cycle_count, 6);
        check("glitch_halted", bus.halted, 0);

        // Second press while waiting for the tick
        wait_phase(0);
        push_pulse();
        wait_phase(11);
        bus.step_btn = 1'b1;
        step_cyc(6);
        bus.step_btn = 1'b0;
        step_cyc(6);
        bus.step_btn = 1'b1;
        step_cyc(12);
        bus.step_btn = 1'b0;
        wait_phase(15);
        check("double_outstanding", exp_q.size(), 0);
        check("double_count", bus.cycle_count, 7);

        // Halt on the same edge as a sampled tick rise
        wait_phase(0);
        bus.run_sw = 1'b1;
        wait_phase(10);
        bus.halt_req = 1'b1;
        step_cyc(1);
        check("halt_cpu_en", bus.cpu_en, 0);
        check("halt_halted", bus.halted, 1);
        check("halt_running", bus.running, 0);
        bus.halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_phase(0);
            bus.run_sw = ~bus.run_sw;
            wait_phase(15);
        end
        check("halted_hold", bus.halted, 1);
        check("halted_count", bus.cycle_count, 7);
        bus.run_sw = 1'b0;
        step_cyc(10);
        rst = 1'b1;
        exp_q.delete();
        exp_count = 0;
        step_cyc(2);
        rst = 1'b0;
        step_cyc(1);
        check("halt_rst_halted", bus.halted, 0);
        check("halt_rst_running", bus.running, 0);
        check("halt_rst_count", bus.cycle_count, 0);

        // Saturation over 20 ticks with a 4-bit counter
        wait_phase(0);
        for (int i = 0; i < 20; i++) push_pulse();
        bus.run_sw = 1'b1;
        repeat (20) wait_phase(15);
        check("sat_outstanding", exp_q.size(), 0);
        check("sat_count", bus.cycle_count, SAT);
        bus.run_sw = 1'b0;
        step_cyc(10);
        check("sat_running", bus.running, 0);
        check("sat_hold", bus.cycle_count, SAT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
